// File: rtl/mul_arb_pkg.sv
// Shared widths and the response tag bundle for mul_arbiter.
// Tag ids are carried at the widest legal width (8 requesters).
package mul_arb_pkg;

  localparam int MUL_OP_W         = 16;
  localparam int MUL_PROD_W       = 32;
  localparam int MUL_ARB_ID_MAX_W = 3;

  typedef struct packed {
    logic                        v;
    logic [MUL_ARB_ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_16b.sv
// Unsigned 16x16 multiplier with LAT register stages.
// Product registers clear on reset.
module mul_16b
  import mul_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MUL_OP_W-1:0]   i_a,
  input  logic [MUL_OP_W-1:0]   i_b,
  output logic [MUL_PROD_W-1:0] o_p
);

  logic [MUL_PROD_W-1:0] r_p [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++)
        r_p[i] <= '0;
    end else begin
      r_p[0] <= MUL_PROD_W'(i_a) * MUL_PROD_W'(i_b);
      for (int i = 1; i < LAT; i++)
        r_p[i] <= r_p[i-1];
    end
  end

  assign o_p = r_p[LAT-1];

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: search starts one past i_ptr.
// Returns one-hot grant, encoded index and an any-grant flag.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = W'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one mul_16b among N_REQ requesters.
// Define MUL_ARB_PRIO_EN to give requester 0 absolute priority.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int MUL_LAT = 1,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*MUL_OP_W-1:0] req_a,
  input  logic [N_REQ*MUL_OP_W-1:0] req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [MUL_PROD_W-1:0]     rsp_data
);

  logic [ID_W-1:0]       r_last;
  logic [N_REQ-1:0]      w_rr_req;
  logic [N_REQ-1:0]      w_rr_gnt;
  logic [ID_W-1:0]       w_rr_idx;
  logic                  w_rr_any;
  logic [N_REQ-1:0]      w_sel_gnt;
  logic [ID_W-1:0]       w_sel_idx;
  logic                  w_upd;
  logic                  w_xfer;

  logic [MUL_OP_W-1:0]   r_iss_a;
  logic [MUL_OP_W-1:0]   r_iss_b;
  logic [ID_W-1:0]       r_iss_id;
  logic                  r_iss_v;
  tag_t                  r_tag [MUL_LAT];
  logic [MUL_PROD_W-1:0] w_prod;

  logic                  r_rsp_v;
  logic [ID_W-1:0]       r_rsp_id;
  logic [MUL_PROD_W-1:0] r_rsp_data;

  rr_pick #(
    .N (N_REQ),
    .W (ID_W)
  ) u_pick (
    .i_req (w_rr_req),
    .i_ptr (r_last),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_any (w_rr_any)
  );

  always_comb begin
`ifdef MUL_ARB_PRIO_EN
    // requester 0 bypasses the rotation and leaves the pointer alone
    w_rr_req  = req_valid & ~N_REQ'(1);
    w_sel_gnt = req_valid[0] ? N_REQ'(1) : w_rr_gnt;
    w_sel_idx = req_valid[0] ? '0 : w_rr_idx;
    w_upd     = !req_valid[0] && w_rr_any;
`else
    w_rr_req  = req_valid;
    w_sel_gnt = w_rr_gnt;
    w_sel_idx = w_rr_idx;
    w_upd     = w_rr_any;
`endif
  end

  assign req_ready = rst ? '0 : w_sel_gnt;
  assign w_xfer    = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= ID_W'(N_REQ - 1);
      r_iss_a  <= '0;
      r_iss_b  <= '0;
      r_iss_id <= '0;
      r_iss_v  <= 1'b0;
    end else begin
      r_iss_v <= w_xfer;
      if (w_xfer) begin
        r_iss_a  <= req_a[int'(w_sel_idx)*MUL_OP_W +: MUL_OP_W];
        r_iss_b  <= req_b[int'(w_sel_idx)*MUL_OP_W +: MUL_OP_W];
        r_iss_id <= w_sel_idx;
      end
      if (w_upd)
        r_last <= w_rr_idx;
    end
  end

  mul_16b #(
    .LAT (MUL_LAT)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .i_a (r_iss_a),
    .i_b (r_iss_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++)
        r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{v: r_iss_v, id: MUL_ARB_ID_MAX_W'(r_iss_id)};
      for (int i = 1; i < MUL_LAT; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  // registered response port: accept edge k -> visible after edge k+1+MUL_LAT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_v    <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else begin
      r_rsp_v    <= r_tag[MUL_LAT-1].v;
      r_rsp_id   <= ID_W'(r_tag[MUL_LAT-1].id);
      r_rsp_data <= w_prod;
    end
  end

  assign rsp_valid = r_rsp_v;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule
